// File: rtl/program_loader.sv
// Boot loader: assembles a byte stream into 16-bit words, writes RAM from 0, verifies XOR checksum.
// Latency: one WRITE cycle after each LO byte; done/error assert the cycle after the CHK byte.
// Backpressure: byte_ready is low in IDLE, WRITE, DONE and ERR; a low byte_valid stalls with no timeout.
module program_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_data,
   output logic              ram_wr,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHECK, S_DONE, S_ERR
   } state_t;

   // Largest legal image; a full image writes every address exactly once.
   localparam logic [16:0]     MAX_LEN = 17'd1 << ADDR_W;
   localparam logic [ADDR_W:0] WC_ONE  = 1;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  len_hi;
   logic [7:0]  hi_byte;
   logic [7:0]  checksum;
   logic [15:0] length;
   logic [15:0] len_in;
   logic [15:0] wc_inc;
   logic        xfer;
   logic        load_start;

   // Receiving states are the only ones that accept bytes.
   assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                       (state == S_DATA_LO) || (state == S_CHECK);
   assign xfer       = byte_valid && byte_ready;
   assign len_in     = {len_hi, byte_in};
   assign wc_inc     = 16'(word_count) + 16'd1;
   // A start outside IDLE/DONE/ERR is deliberately ignored so a glitchy host cannot restart a load.
   assign load_start = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      state_nxt = state;
      ram_wr    = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      cpu_hold  = 1'b1;
      case (state)
         S_IDLE:    if (start) state_nxt = S_LEN_HI;
         S_LEN_HI:  if (xfer) state_nxt = S_LEN_LO;
         S_LEN_LO: begin
            if (xfer) begin
               if ({1'b0, len_in} > MAX_LEN) state_nxt = S_ERR;
               else if (len_in == 16'd0)     state_nxt = S_CHECK;
               else                          state_nxt = S_DATA_HI;
            end
         end
         S_DATA_HI: if (xfer) state_nxt = S_DATA_LO;
         S_DATA_LO: if (xfer) state_nxt = S_WRITE;
         S_WRITE: begin
            ram_wr    = 1'b1;
            state_nxt = (wc_inc == length) ? S_CHECK : S_DATA_HI;
         end
         S_CHECK: begin
            if (xfer) state_nxt = (byte_in == checksum) ? S_DONE : S_ERR;
         end
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) state_nxt = S_LEN_HI;
         end
         S_ERR: begin
            error = 1'b1;
            if (start) state_nxt = S_LEN_HI;
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Datapath: length capture, word assembly, checksum and write counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_hi     <= '0;
         hi_byte    <= '0;
         checksum   <= '0;
         length     <= '0;
         ram_addr   <= '0;
         ram_data   <= '0;
         word_count <= '0;
      end else begin
         if (load_start) begin
            word_count <= '0;
            checksum   <= '0;
         end
         case (state)
            S_LEN_HI:  if (xfer) len_hi <= byte_in;
            S_LEN_LO:  if (xfer) length <= len_in;
            S_DATA_HI: begin
               if (xfer) begin
                  hi_byte  <= byte_in;
                  checksum <= checksum ^ byte_in;
               end
            end
            S_DATA_LO: begin
               // Address and data are staged here so they are stable for the WRITE cycle and hold after.
               if (xfer) begin
                  checksum <= checksum ^ byte_in;
                  ram_data <= {hi_byte, byte_in};
                  ram_addr <= word_count[ADDR_W-1:0];
               end
            end
            S_WRITE:   word_count <= word_count + WC_ONE;
            default:   ;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic [ADDR_W-1:0] ram_addr;
   logic [15:0]       ram_data;
   logic              ram_wr;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   program_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wr(ram_wr),
      .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  stim_q[$];
   logic [23:0] exp_q[$];
   logic [23:0] wr_q[$];
   int          wr_base;
   bit          exp_err;
   int          exp_wc;
   int          dbl_wr = 0;
   bit          prev_wr = 1'b0;

   // Every RAM write seen on the bus, plus a count of back-to-back strobes.
   always @(negedge clk) begin
      if (ram_wr) wr_q.push_back({ram_addr, ram_data});
      if (ram_wr && prev_wr) dbl_wr++;
      prev_wr = ram_wr;
   end

   // Reference: parse the stream by its format rules.
   task automatic build_expect();
      int n;
      logic [7:0] x;
      n = {stim_q[0], stim_q[1]};
      exp_q.delete();
      x = 8'h00;
      if (n > (1 << ADDR_W)) begin
         exp_err = 1'b1;
         exp_wc  = 0;
      end else begin
         for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'(i), stim_q[2+2*i], stim_q[3+2*i]});
            x = x ^ stim_q[2+2*i] ^ stim_q[3+2*i];
         end
         exp_err = (stim_q[2+2*n] != x);
         exp_wc  = n;
      end
   endtask

   task automatic make_image(input int n, input bit bad);
      logic [7:0] x;
      logic [7:0] b;
      stim_q.delete();
      stim_q.push_back(8'(n >> 8));
      stim_q.push_back(8'(n));
      x = 8'h00;
      for (int i = 0; i < 2*n; i++) begin
         b = 8'($urandom);
         stim_q.push_back(b);
         x = x ^ b;
      end
      if (bad) x = x ^ 8'($urandom_range(1, 255));
      stim_q.push_back(x);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Pulses start, then feeds stim_q with random gaps; returns at the negedge after the last transfer.
   task automatic send_stream(input int gap_pct, input int mid_start_at);
      int idx;
      int cyc;
      wr_base = wr_q.size();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < stim_q.size() && cyc < 5000) begin
         byte_valid = ($urandom_range(99) >= 32'(gap_pct));
         byte_in    = byte_valid ? stim_q[idx] : 8'($urandom);
         start      = (idx == mid_start_at);
         if (byte_valid && byte_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      byte_valid = 1'b0;
      start      = 1'b0;
      checks++;
      if (idx !== stim_q.size()) begin
         errors++;
         $display("FAIL stream_timeout: sent %0d bytes, required %0d", idx, stim_q.size());
      end
   endtask

   task automatic test_reset();
      logic [37:0] exp_v;
      exp_v = {1'b1, 37'b0};
      do_reset();
      for (int i = 0; i < 11; i++) begin
         checks++;
         if ({cpu_hold, done, error, byte_ready, ram_wr, ram_addr, ram_data, word_count} !== exp_v) begin
            errors++;
            $display("FAIL reset_idle[%0d]: got hold=%b done=%b err=%b rdy=%b wr=%b addr=%h data=%h wc=%0d", i,
                     cpu_hold, done, error, byte_ready, ram_wr, ram_addr, ram_data, word_count);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_basic();
      logic [23:0] lit[2];
      lit[0] = 24'h001234;
      lit[1] = 24'h01ABCD;
      stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      send_stream(0, -1);
      checks++;
      if (wr_q.size() - wr_base !== 2) begin
         errors++; $display("FAIL basic_nwr: got %0d required 2", wr_q.size() - wr_base);
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (wr_q[wr_base+i] !== lit[i]) begin
               errors++; $display("FAIL basic_wr[%0d]: got %h required %h", i, wr_q[wr_base+i], lit[i]);
            end
         end
      end
      checks++;
      if ({done, error, cpu_hold, word_count} !== {3'b100, 9'd2}) begin
         errors++; $display("FAIL basic_status: done=%b err=%b hold=%b wc=%0d required 1 0 0 2", done, error, cpu_hold, word_count);
      end
      checks++;
      if (dbl_wr !== 0) begin
         errors++; $display("FAIL basic_wr_pulse: %0d multi-cycle strobes, required 0", dbl_wr);
      end
   endtask

   task automatic test_bad_chk();
      stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
      send_stream(0, -1);
      checks++;
      if (wr_q.size() - wr_base !== 2) begin
         errors++; $display("FAIL badchk_nwr: got %0d required 2", wr_q.size() - wr_base);
      end
      checks++;
      if ({done, error, cpu_hold} !== 3'b011) begin
         errors++; $display("FAIL badchk_status: done=%b err=%b hold=%b required 0 1 1", done, error, cpu_hold);
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({error, byte_ready, cpu_hold} !== 3'b011) begin
         errors++; $display("FAIL badchk_restart: err=%b rdy=%b hold=%b required 0 1 1", error, byte_ready, cpu_hold);
      end
      do_reset();
   endtask

   task automatic test_zero_and_overflow();
      stim_q = '{8'h00, 8'h00, 8'h00};
      send_stream(0, -1);
      checks++;
      if ({wr_q.size() - wr_base, done, error, word_count} !== {32'd0, 2'b10, 9'd0}) begin
         errors++; $display("FAIL zero_len: nwr=%0d done=%b err=%b wc=%0d required 0 1 0 0",
                            wr_q.size() - wr_base, done, error, word_count);
      end
      stim_q = '{8'h01, 8'h01};
      send_stream(0, -1);
      checks++;
      if ({wr_q.size() - wr_base, error, done, cpu_hold, byte_ready} !== {32'd0, 4'b1010}) begin
         errors++; $display("FAIL overflow: nwr=%0d err=%b done=%b hold=%b rdy=%b required 0 1 0 1 0",
                            wr_q.size() - wr_base, error, done, cpu_hold, byte_ready);
      end
   endtask

   task automatic test_stall();
      wr_base = wr_q.size();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      byte_valid = 1'b1;
      byte_in = 8'h00; @(negedge clk);
      byte_in = 8'h01; @(negedge clk);
      byte_in = 8'hFF; @(negedge clk);
      byte_valid = 1'b0;
      byte_in = 8'h5A;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({byte_ready, ram_wr, word_count} !== {2'b10, 9'd0}) begin
            errors++; $display("FAIL stall[%0d]: rdy=%b wr=%b wc=%0d required 1 0 0", i, byte_ready, ram_wr, word_count);
         end
      end
      byte_valid = 1'b1;
      byte_in = 8'h00;
      @(negedge clk);
      checks++;
      if ({ram_wr, ram_addr, ram_data} !== {1'b1, 8'h00, 16'hFF00}) begin
         errors++; $display("FAIL stall_write: wr=%b addr=%h data=%h required 1 00 ff00", ram_wr, ram_addr, ram_data);
      end
      byte_in = 8'hFF;
      @(negedge clk);
      @(negedge clk);
      byte_valid = 1'b0;
      checks++;
      if ({done, error, cpu_hold, word_count} !== {3'b100, 9'd1}) begin
         errors++; $display("FAIL stall_done: done=%b err=%b hold=%b wc=%0d required 1 0 0 1", done, error, cpu_hold, word_count);
      end
   endtask

   task automatic test_random(input int iters, input int fixed_n, input int mid_start);
      int n;
      for (int it = 0; it < iters; it++) begin
         n = (fixed_n > 0) ? fixed_n : int'($urandom_range(1, 12));
         make_image(n, (fixed_n > 0) ? 1'b0 : bit'($urandom_range(1)));
         build_expect();
         send_stream((fixed_n > 0) ? 0 : int'($urandom_range(50)), mid_start);
         checks++;
         if (wr_q.size() - wr_base !== exp_q.size()) begin
            errors++; $display("FAIL rand%0d_nwr: got %0d required %0d", it, wr_q.size() - wr_base, exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               checks++;
               if (wr_q[wr_base+i] !== exp_q[i]) begin
                  errors++; $display("FAIL rand%0d_wr[%0d]: got %h required %h", it, i, wr_q[wr_base+i], exp_q[i]);
               end
            end
         end
         checks++;
         if ({done, error, cpu_hold, 32'(word_count)} !== {~exp_err, exp_err, exp_err, 32'(exp_wc)}) begin
            errors++; $display("FAIL rand%0d_status: done=%b err=%b hold=%b wc=%0d required done=%b err=%b wc=%0d",
                               it, done, error, cpu_hold, word_count, ~exp_err, exp_err, exp_wc);
         end
      end
      checks++;
      if (dbl_wr !== 0) begin
         errors++; $display("FAIL rand_wr_pulse: %0d multi-cycle strobes, required 0", dbl_wr);
      end
   endtask

   task automatic test_reset_mid();
      stim_q = '{8'h00, 8'h03};
      send_stream(0, -1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({cpu_hold, done, error, byte_ready, ram_wr, ram_addr, ram_data, word_count} !== {1'b1, 37'b0}) begin
         errors++; $display("FAIL reset_mid: hold=%b done=%b err=%b rdy=%b wr=%b addr=%h data=%h wc=%0d",
                            cpu_hold, done, error, byte_ready, ram_wr, ram_addr, ram_data, word_count);
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      test_reset();
      test_basic();
      test_bad_chk();
      test_zero_and_overflow();
      test_stall();
      test_random(6, 0, -1);
      test_random(2, 5, 4);
      test_random(1, 1 << ADDR_W, -1);
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
